// File: rtl/mod_tbase.sv
// mod_tbase: timebase and parameter sequencer feeding mod_dds.
// Queues pulse descriptors (parameter word + sample length). It plays them in order,
// driving the word on m_mem_dout and a 0..len-1 ramp on m_t. Pulses are chained
// back-to-back with no gap cycles.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_len   descriptor input handshake (s_len == 0 is dropped)
//   s_rep         (MOD_TBASE_REPEAT_EN only) replay this entry while the queue is empty
//   m_mem_dout    parameter word to mod_dds
//   m_t           time base to mod_dds t_in
//   m_en          current sample valid
//   done          one-cycle pulse on the last sample of each pulse
//   busy          playing or queue non-empty (registered from previous-cycle state)
//   drop_cnt      saturating count of discarded zero-length descriptors
//
// Optional feature macro: MOD_TBASE_REPEAT_EN (adds s_rep and pulse replay).
module mod_tbase #(
  parameter int unsigned BT    = 16,
  parameter int unsigned DW    = 256,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic [BT-1:0] s_len,
`ifdef MOD_TBASE_REPEAT_EN
  input  logic          s_rep,
`endif
  output logic [DW-1:0] m_mem_dout,
  output logic [BT-1:0] m_t,
  output logic          m_en,
  output logic          done,
  output logic          busy,
  output logic [7:0]    drop_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   CntOne = (AW+1)'(1);
  localparam logic [AW:0]   CntMax = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [BT-1:0] TOne   = BT'(1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e        r_state;
  logic [DW-1:0] r_mem_data [DEPTH];
  logic [BT-1:0] r_mem_len  [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_ready;
  logic [DW-1:0] r_dout;
  logic [BT-1:0] r_len;
  logic [BT-1:0] r_t;
  logic          r_en;
  logic          r_done;
  logic          r_busy;
  logic [7:0]    r_drop;

  logic          w_push, w_drop, w_nempty, w_pop, w_rep;
  logic [AW:0]   w_count_nxt;

`ifdef MOD_TBASE_REPEAT_EN
  logic          r_mem_rep [DEPTH];
  logic          r_rep;
  assign w_rep = r_rep;
`else
  assign w_rep = 1'b0;
`endif

  assign w_push   = s_valid && r_ready && (s_len != '0);
  assign w_drop   = s_valid && r_ready && (s_len == '0);
  assign w_nempty = (r_count != '0);
  // r_done marks the last sample of the running pulse, so it doubles as the pulse-end flag.
  assign w_pop    = w_nempty && ((r_state == StIdle) || ((r_state == StRun) && r_done));

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CntOne;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CntOne;
    end
  end

  // Queue storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= s_data;
      r_mem_len[r_wptr]  <= s_len;
`ifdef MOD_TBASE_REPEAT_EN
      r_mem_rep[r_wptr]  <= s_rep;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
      r_dout  <= '0;
      r_len   <= '0;
      r_t     <= '0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= '0;
`ifdef MOD_TBASE_REPEAT_EN
      r_rep   <= 1'b0;
`endif
    end else begin
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < CntMax);
      r_busy  <= r_en || w_nempty;
      if (w_push) r_wptr <= r_wptr + PtrOne;
      if (w_drop && (r_drop != 8'hff)) r_drop <= r_drop + 8'd1;

      if (w_pop) begin
        // Load the head descriptor; covers both idle start and gapless chaining.
        r_rptr  <= r_rptr + PtrOne;
        r_state <= StRun;
        r_dout  <= r_mem_data[r_rptr];
        r_len   <= r_mem_len[r_rptr];
        r_t     <= '0;
        r_en    <= 1'b1;
        r_done  <= (r_mem_len[r_rptr] == TOne);
`ifdef MOD_TBASE_REPEAT_EN
        r_rep   <= r_mem_rep[r_rptr];
`endif
      end else if (r_state == StRun) begin
        if (!r_done) begin
          r_t    <= r_t + TOne;
          r_done <= ((r_t + TOne) == (r_len - TOne));
        end else if (w_rep) begin
          r_t    <= '0;
          r_done <= (r_len == TOne);
        end else begin
          r_state <= StIdle;
          r_t     <= '0;
          r_en    <= 1'b0;
          r_done  <= 1'b0;
        end
      end
    end
  end

  assign s_ready    = r_ready;
  assign m_mem_dout = r_dout;
  assign m_t        = r_t;
  assign m_en       = r_en;
  assign done       = r_done;
  assign busy       = r_busy;
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_mod_tbase.sv
// Directed testbench for mod_tbase. Inputs change and outputs are sampled 1 ns after
// each rising edge.
module tb_mod_tbase;
  localparam int BT    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic [BT-1:0] s_len = '0;
`ifdef MOD_TBASE_REPEAT_EN
  logic          s_rep = 1'b0;
`endif
  logic [DW-1:0] m_mem_dout;
  logic [BT-1:0] m_t;
  logic          m_en;
  logic          done;
  logic          busy;
  logic [7:0]    drop_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mod_tbase #(.BT(BT), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_len      (s_len),
`ifdef MOD_TBASE_REPEAT_EN
    .s_rep      (s_rep),
`endif
    .m_mem_dout (m_mem_dout),
    .m_t        (m_t),
    .m_en       (m_en),
    .done       (done),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [BT-1:0] l);
    s_valid = 1'b1;
    s_data  = d;
    s_len   = l;
    tick;
    s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int k;

    // Reset state
    rst = 1'b1;
    tick; tick; tick;
    chk("rst_ready", s_ready, 0);
    chk("rst_en", m_en, 0);
    chk("rst_t", m_t, 0);
    chk("rst_dout", m_mem_dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    tick;
    chk("rel_ready", s_ready, 1);

    // Single pulse A, len 4
    push(32'hA0A0_0001, 16'd4);
    chk("a_en_lat", m_en, 0);
    chk("a_busy0", busy, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("a_en", m_en, 1);
      chk("a_t", m_t, 64'(i));
      chk("a_dout", m_mem_dout, 32'hA0A0_0001);
      chk("a_done", done, (i == 3) ? 64'd1 : 64'd0);
      chk("a_busy", busy, 1);
    end
    tick;
    chk("a_en_off", m_en, 0);
    chk("a_t_idle", m_t, 0);
    chk("a_dout_hold", m_mem_dout, 32'hA0A0_0001);
    chk("a_busy_lag", busy, 1);
    tick;
    chk("a_busy_off", busy, 0);

    // B len 3 then C len 2 on consecutive cycles
    s_valid = 1'b1; s_data = 32'hB0B0_0002; s_len = 16'd3;
    tick;
    s_data = 32'hC0C0_0003; s_len = 16'd2;
    tick;
    s_valid = 1'b0;
    chk("b_t0", m_t, 0);
    chk("b_dout", m_mem_dout, 32'hB0B0_0002);
    chk("b_en", m_en, 1);
    tick; chk("b_t1", m_t, 1); chk("b_done1", done, 0);
    tick; chk("b_t2", m_t, 2); chk("b_done2", done, 1);
    tick; chk("c_t0", m_t, 0); chk("c_dout", m_mem_dout, 32'hC0C0_0003);
    chk("c_en", m_en, 1); chk("c_done0", done, 0);
    tick; chk("c_t1", m_t, 1); chk("c_done1", done, 1);
    tick; chk("c_en_off", m_en, 0);

    // Backpressure during a long pulse
    push(32'h0000_0100, 16'd100);
    tick;
    chk("p_t0", m_t, 0);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h0000_5100 + 32'(i);
      s_len   = 16'd5;
      if (s_ready) acc++;
      tick;
    end
    s_valid = 1'b0;
    chk("p_accepted", 64'(acc), 4);
    chk("p_ready_full", s_ready, 0);
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      tick;
      k++;
    end
    chk("p_done_seen", done, 1);
    chk("p_last_t", m_t, 99);
    chk("p_ready_at_end", s_ready, 0);
    tick;
    chk("p_ready_back", s_ready, 1);
    chk("p_q0_dout", m_mem_dout, 32'h0000_5100);
    chk("p_q0_t", m_t, 0);
    chk("p_q0_en", m_en, 1);
    k = 0;
    while (m_en !== 1'b0 && k < 100) begin
      tick;
      k++;
    end
    chk("p_drain", m_en, 0);
    chk("p_last_word", m_mem_dout, 32'h0000_5103);
    tick;
    chk("p_busy_off", busy, 0);

    // D len 2, X len 0 (dropped), E len 1
    s_valid = 1'b1; s_data = 32'hD0D0_0004; s_len = 16'd2;
    tick;
    s_data = 32'hEEEE_FFFF; s_len = 16'd0;
    tick;
    chk("d_t0", m_t, 0); chk("d_dout", m_mem_dout, 32'hD0D0_0004);
    chk("x_drop", drop_cnt, 1);
    s_data = 32'hE0E0_0005; s_len = 16'd1;
    tick;
    s_valid = 1'b0;
    chk("d_t1", m_t, 1); chk("d_done", done, 1);
    tick;
    chk("e_t0", m_t, 0); chk("e_dout", m_mem_dout, 32'hE0E0_0005);
    chk("e_en", m_en, 1); chk("e_done", done, 1);
    tick;
    chk("e_en_off", m_en, 0); chk("e_done_off", done, 0);
    chk("e_drop_keep", drop_cnt, 1);

    // Drop counter saturation
    s_valid = 1'b1; s_len = 16'd0;
    for (int i = 0; i < 260; i++) tick;
    s_valid = 1'b0;
    chk("sat_drop", drop_cnt, 255);
    chk("sat_en", m_en, 0);

    // Reset mid-pulse with two entries queued
    s_valid = 1'b1; s_data = 32'h1111_0010; s_len = 16'd10;
    tick;
    s_data = 32'h2222_0003; s_len = 16'd3;
    tick;
    s_data = 32'h3333_0003;
    tick;
    s_valid = 1'b0;
    tick; tick; tick; tick;
    chk("r_t5", m_t, 5);
    chk("r_busy", busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("r_en", m_en, 0);
    chk("r_t", m_t, 0);
    chk("r_dout", m_mem_dout, 0);
    chk("r_done", done, 0);
    chk("r_busy_off", busy, 0);
    chk("r_drop", drop_cnt, 0);
    chk("r_ready_low", s_ready, 0);
    tick;
    chk("r_ready_high", s_ready, 1);
    tick; tick; tick;
    chk("r_flushed_en", m_en, 0);
    chk("r_flushed_busy", busy, 0);

`ifdef MOD_TBASE_REPEAT_EN
    // Replay F until G is queued
    s_rep = 1'b1;
    push(32'hF0F0_0006, 16'd3);
    s_rep = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick;
      chk("f_t", m_t, 64'(i % 3));
      chk("f_en", m_en, 1);
      chk("f_done", done, (i % 3 == 2) ? 64'd1 : 64'd0);
      chk("f_dout", m_mem_dout, 32'hF0F0_0006);
    end
    s_valid = 1'b1; s_data = 32'h6060_0007; s_len = 16'd2;
    tick;
    s_valid = 1'b0;
    chk("f_rep_t0", m_t, 0); chk("f_rep_dout", m_mem_dout, 32'hF0F0_0006);
    tick; chk("f_rep_t1", m_t, 1);
    tick; chk("f_rep_t2", m_t, 2); chk("f_rep_done", done, 1);
    tick; chk("g_t0", m_t, 0); chk("g_dout", m_mem_dout, 32'h6060_0007);
    chk("g_en", m_en, 1);
    tick; chk("g_t1", m_t, 1); chk("g_done", done, 1);
    tick; chk("g_en_off", m_en, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_tbase.md
Name: mod_tbase

Overview:
- Timebase and parameter sequencer directly upstream of mod_dds.
- Accepts queued pulse descriptors, each a DW-bit parameter word plus a sample length.
- Plays descriptors in order: drives each parameter word onto mod_dds mem_dout and a t_in ramp 0..len-1.
- Chains pulses back-to-back with no gap cycles.

Parameters:
BT, 16, width of time base t / length field (matches mod_dds BT)
DW, 256, parameter word width (mod_dds mem_dout layout, opaque here)
DEPTH, 4, descriptor queue entries; power of 2, >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_valid  in  1  descriptor valid
s_ready  out  1  queue can accept descriptor
s_data  in  DW  parameter word
s_len  in  BT  pulse length in samples; 0 = empty pulse
m_mem_dout  out  DW  parameter word to mod_dds
m_t  out  BT  time base to mod_dds t_in
m_en  out  1  current sample valid
done  out  1  one-cycle pulse on last sample of each pulse
busy  out  1  m_en high or queue non-empty
drop_cnt  out  8  count of zero-length descriptors discarded, saturating

Behaviour:
- Handshake
  - Transfer occurs when s_valid && s_ready.
  - s_ready = (count < DEPTH), registered from occupancy.
  - Push and pop may occur in the same cycle; count is unchanged.
  - A descriptor with s_len == 0 is accepted (s_ready honoured) but not written to the queue; drop_cnt increments and saturates at 255.
- FSM states: IDLE, RUN.
  - IDLE: m_en = 0. If the queue is non-empty, pop the head; next cycle enter RUN with m_mem_dout = data, m_t = 0, m_en = 1.
  - Latency: a descriptor accepted into an empty queue while IDLE produces m_en = 1 two cycles after the handshake (1 cycle queue write, 1 cycle pop/register).
  - RUN: m_t increments by 1 each cycle. On the cycle where m_t == len-1, done = 1.
    - If the queue is non-empty in that cycle, pop the head. Next cycle m_mem_dout = new data, m_t = 0, m_en = 1; stay in RUN with no gap.
    - Otherwise go to IDLE next cycle.
  - len = 1: done is asserted on the t = 0 cycle.
- Outputs in IDLE: m_t = 0; m_mem_dout holds the last played word; m_en = 0.
- Wrap-around: len max is 2^BT-1, so m_t tops out at 2^BT-2 and never wraps inside a pulse. Queue pointers wrap modulo DEPTH.
- Reset (any cycle, including mid-pulse): next cycle the queue is flushed and
  - FSM = IDLE, m_en = 0, m_t = 0, m_mem_dout = 0, done = 0, busy = 0, drop_cnt = 0;
  - s_ready = 0 while rst is high, 1 on the first cycle after release.
  - Descriptors presented during rst are not accepted.
- All outputs are registered.

Optional Feature:
- Macro: MOD_TBASE_REPEAT_EN.
- When defined:
  - Extra port s_rep (in, 1) is stored per queue entry.
  - At the end of a pulse with rep = 1 and an empty queue, the same entry replays: m_t returns to 0 next cycle, m_en stays 1, done still pulses.
  - Replay continues until a descriptor is queued, which then takes over at the next pulse end.
- When undefined: no s_rep port; playback stops at the end of the pulse when the queue is empty.

Test Plan:
- Reset release, push {data = A, len = 4} into an idle block -> m_en high 4 cycles starting 2 cycles after handshake; m_t = 0,1,2,3; done at m_t = 3; m_mem_dout = A; busy drops the cycle after m_en falls.
- Push {B, len = 3} then {C, len = 2} on consecutive cycles -> m_t = 0,1,2,0,1 contiguous; m_mem_dout changes B->C exactly at the second m_t = 0; done pulses twice.
- With a len = 100 pulse playing, offer 6 descriptors -> only 4 accepted, s_ready low; at the pulse end one pop occurs and s_ready returns high the next cycle.
- Push {D, 2}, {X, 0}, {E, 1} -> X dropped, drop_cnt = 1; output m_t = 0,1,0 with no gap; E's done on its single sample.
- Assert rst for 1 cycle at m_t = 5 of a len = 10 pulse with 2 entries queued -> next cycle m_en = 0, m_t = 0, m_mem_dout = 0; queued entries never played.
- With MOD_TBASE_REPEAT_EN, push {F, len = 3, rep = 1}, wait 9 cycles, then push {G, 2} -> m_t sequence 0,1,2 repeated until G queued; G starts at the next F pulse end with no gap.
